// File: rtl/fifo_word_serializer.sv
// Pops IN_WIDTH words from a SyncFIFO read port and emits them as OUT_WIDTH beats, LSB slice first.
// Define SERIALIZER_PREFETCH_EN to pop the next word during SEND for zero-bubble word streams.
module fifo_word_serializer #(
    parameter int IN_WIDTH  = 3072,
    parameter int OUT_WIDTH = 64,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_rempty,
    output logic                 fifo_rinc,
    input  logic [IN_WIDTH-1:0]  fifo_rdata,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_last,
    output logic                 busy,
    output logic [CNT_W-1:0]     words_sent,
    output logic [1:0]           dbg_state
);

    localparam int BEATS = IN_WIDTH / OUT_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    if ((IN_WIDTH % OUT_WIDTH) != 0 || BEATS < 2) begin : g_param_check
        $error("fifo_word_serializer: IN_WIDTH must be a multiple of OUT_WIDTH with at least 2 beats");
    end

    // Handshake: a beat transfers on a rising edge where m_valid && m_ready;
    // m_valid is a pure function of state and never looks at m_ready.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_SEND = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [IN_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [CNT_W-1:0]    words_q, words_d;
    logic                is_last;

`ifdef SERIALIZER_PREFETCH_EN
    logic next_valid_q, next_valid_d;
`endif

    assign is_last = (beat_q == LAST_BEAT);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        beat_d    = beat_q;
        words_d   = words_q;
        fifo_rinc = 1'b0;
`ifdef SERIALIZER_PREFETCH_EN
        next_valid_d = next_valid_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_rempty) begin
                    fifo_rinc = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                shift_d = fifo_rdata;
                beat_d  = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (m_ready) begin
                    if (!is_last) begin
                        shift_d = shift_q >> OUT_WIDTH;
                        beat_d  = beat_q + 1'b1;
                    end else begin
                        words_d = words_q + 1'b1;
`ifdef SERIALIZER_PREFETCH_EN
                        if (next_valid_q) begin
                            shift_d      = fifo_rdata;
                            beat_d       = '0;
                            next_valid_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
`else
                        state_d = S_IDLE;
`endif
                    end
                end
`ifdef SERIALIZER_PREFETCH_EN
                // No pop on the leaving-to-IDLE cycle, so IDLE never sees a pending word.
                if (!next_valid_q && !fifo_rempty && !(m_ready && is_last)) begin
                    fifo_rinc    = 1'b1;
                    next_valid_d = 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            beat_q  <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            beat_q  <= beat_d;
            words_q <= words_d;
        end
    end

`ifdef SERIALIZER_PREFETCH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            next_valid_q <= 1'b0;
        end else begin
            next_valid_q <= next_valid_d;
        end
    end
`endif

    assign m_valid    = (state_q == S_SEND);
    assign m_data     = shift_q[OUT_WIDTH-1:0];
    assign m_last     = (state_q == S_SEND) && is_last;
    assign busy       = (state_q != S_IDLE);
    assign words_sent = words_q;
    assign dbg_state  = state_q;

endmodule
